zap_mac_seq: RTL and testbench
==============================

// Module: zap_mac_seq
// PURPOSE
//  Parametrised sequential multiply-accumulate unit for the ZAP execute stage.
//  Computes {hi,lo} = rm*rs + {rh,rn} at DATA_W operand width. One SLICE_W x SLICE_W partial product is issued per cycle.
//  Supports signed/unsigned operands and full 2*DATA_W (long) results, so UMULL/SMULL/UMLAL/SMLAL run in one pass.
//  Sits beside the ALU. The ALU stalls on o_busy and consumes o_rd_lo/o_rd_hi when o_done pulses.
// PARAMETERS
//  DATA_W   32  operand width; must be a multiple of SLICE_W.
//  SLICE_W  16  multiplier slice width; K = DATA_W/SLICE_W; partial products = K*K.
// PORTS
//  i_clk                   in   1         clock
//  i_reset                 in   1         synchronous, active-high reset
//  i_clear_from_writeback  in   1         flush; aborts any operation
//  i_data_stall            in   1         freeze all state
//  i_clear_from_alu        in   1         flush; lower priority than stall
//  i_start                 in   1         request; sampled only in IDLE
//  i_signed                in   1         1 = two's-complement rm/rs
//  i_acc                   in   1         1 = add {i_rh,i_rn}; 0 = add zero
//  i_rm, i_rs              in   DATA_W    multiplicand, multiplier
//  i_rn, i_rh              in   DATA_W    accumulator low/high; captured with the operands
//  o_rd_lo, o_rd_hi        out  DATA_W    result halves; registered; hold until next o_done
//  o_busy                  out  1         unit occupied; pipeline must stall
//  o_done                  out  1         one-cycle pulse; result valid this cycle
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, accumulator=0, o_rd_lo=o_rd_hi=0, o_done=0, o_busy=0.
//  Control priority: i_reset > i_clear_from_writeback > i_data_stall > i_clear_from_alu > normal.
//   Both clears force IDLE and zero the accumulator. They do not touch o_rd_*. No o_done follows.
//   A stall holds state, counter, accumulator and o_rd_* unchanged. o_busy/o_done keep their state-decoded values.
//  States:
//   IDLE: o_busy=0. On i_start: o_busy=1 combinationally in the same cycle.
//         Capture |rm|, |rs|, neg = i_signed & (rm[MSB]^rs[MSB]), and acc = i_acc ? {rh,rn} : 0. Go to MUL.
//   MUL:  K*K cycles. Counter j drives slice pair (i = j/K, k = j%K).
//         acc_p += slice_i(|rm|)*slice_k(|rs|) << (SLICE_W*(i+k)). Go to FIX after j = K*K-1.
//   FIX:  if neg, prod = -prod (mod 2^(2*DATA_W)). Go to ACC.
//   ACC:  result = prod + acc (mod 2^(2*DATA_W); carry-out discarded). Load o_rd_lo/o_rd_hi. Go to DONE.
//   DONE: o_done=1, o_busy=0 for one cycle. Go to IDLE.
//  Latency: i_start to o_done = K*K+3 cycles (7 at defaults), plus stall cycles.
//  Magnitude of the most negative operand (e.g. 0x80000000) is representable as unsigned DATA_W; no special case.
//  i_start outside IDLE is ignored. Operand changes after capture are ignored.
//  The product accumulator (prod) is a separate 2*DATA_W register from the captured addend.
//  i_signed=0 never negates, regardless of the operand MSBs.
// STRUCTURE
//  zap_mac_defs.vh: state localparams (IDLE, MUL, FIX, ACC, DONE) and the state-width constant. Shared with the ALU for debug decode.
//  Sub-module zap_mul_slice: registered-free unsigned SLICE_W x SLICE_W -> 2*SLICE_W multiplier, one instance.
//  Top level holds the FSM, the slice counter, the operand/addend capture registers and the 2*DATA_W adder.
// TESTING
//  1. Unsigned long, rm=rs=0xFFFFFFFF, i_acc=0 -> o_done at cycle 7; hi=0xFFFFFFFE, lo=0x00000001.
//  2. Signed, rm=0xFFFFFFFF (-1), rs=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB.
//     Signed, rm=rs=0x80000000 -> hi=0x40000000, lo=0.
//  3. Accumulate, rm=3, rs=5, rh=0, rn=0xFFFFFFFF -> hi=0x00000001, lo=0x0000000E.
//     Wrap case: signed -1*1 + {0,1} -> hi=lo=0.
//  4. i_data_stall high for 3 cycles during MUL -> o_done delayed exactly 3 cycles; result unchanged vs. case 1.
//  5. i_clear_from_alu in FIX -> IDLE next cycle; no o_done; o_rd_* keep their previous values.
//     Clear together with stall -> stall wins. i_clear_from_writeback together with stall -> clear wins.
//  6. i_start pulsed while busy with different operands -> ignored; first result returned.
//     Back-to-back: i_start in the cycle after DONE -> accepted; o_busy=1 in that cycle.

Source files
------------

// File: rtl/zap_mac_seq_pkg.sv
// Shared definitions for the ZAP sequential multiply-accumulate unit.
// The state encoding is also decoded by the ALU for debug visibility.
package zap_mac_seq_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SLICE_W = 16;
  localparam int STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_FIX  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } mac_state_e;

  // Counter width able to index k*k partial products (at least one bit).
  function automatic int slice_cnt_w(input int k);
    if (k * k > 1) begin
      slice_cnt_w = $clog2(k * k);
    end else begin
      slice_cnt_w = 1;
    end
  endfunction

endpackage

// File: rtl/zap_mac_seq_if.sv
// Request/result bundle between the ALU (master) and the MAC unit (slave).
interface zap_mac_seq_if #(
  parameter int DATA_W = 32
);

  logic              i_start;
  logic              i_signed;
  logic              i_acc;
  logic [DATA_W-1:0] i_rm;
  logic [DATA_W-1:0] i_rs;
  logic [DATA_W-1:0] i_rn;
  logic [DATA_W-1:0] i_rh;
  logic [DATA_W-1:0] o_rd_lo;
  logic [DATA_W-1:0] o_rd_hi;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_start, i_signed, i_acc, i_rm, i_rs, i_rn, i_rh,
    input  o_rd_lo, o_rd_hi, o_busy, o_done
  );

  modport slave (
    input  i_start, i_signed, i_acc, i_rm, i_rs, i_rn, i_rh,
    output o_rd_lo, o_rd_hi, o_busy, o_done
  );

endinterface

// File: rtl/zap_mul_slice.sv
// Purely combinational unsigned SLICE_W x SLICE_W multiplier producing a
// full-width 2*SLICE_W product; the MAC issues one of these per cycle.
module zap_mul_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0]   a,
  input  logic [SLICE_W-1:0]   b,
  output logic [2*SLICE_W-1:0] p
);

  assign p = {{SLICE_W{1'b0}}, a} * {{SLICE_W{1'b0}}, b};

endmodule

// File: rtl/zap_mac_seq.sv
// Sequential multiply-accumulate for the ZAP execute stage:
// {hi,lo} = rm*rs + {rh,rn}, one slice partial product per cycle.
module zap_mac_seq
  import zap_mac_seq_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear_from_writeback,
  input  logic         i_data_stall,
  input  logic         i_clear_from_alu,
  zap_mac_seq_if.slave mac
);

  localparam int K     = DATA_W / SLICE_W;
  localparam int NPP   = K * K;
  localparam int CNT_W = slice_cnt_w(K);
  localparam int W2    = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPP - 1);

  mac_state_e          state_r;
  mac_state_e          state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   rm_mag_r;
  logic [DATA_W-1:0]   rs_mag_r;
  logic                neg_r;
  logic [W2-1:0]       addend_r;
  logic [W2-1:0]       prod_r;
  logic [DATA_W-1:0]   rd_lo_r;
  logic [DATA_W-1:0]   rd_hi_r;
  logic [SLICE_W-1:0]  slice_a_s;
  logic [SLICE_W-1:0]  slice_b_s;
  logic [2*SLICE_W-1:0] pp_s;
  logic [W2-1:0]       pp_shift_s;
  logic                flush_s;
  logic                advance_s;

  // Two's-complement magnitude; the most negative value maps onto itself as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic             is_signed);
    if (is_signed && v[DATA_W-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  // Writeback flush outranks a stall; an ALU flush only acts when not stalled.
  assign flush_s   = i_clear_from_writeback | (~i_data_stall & i_clear_from_alu);
  assign advance_s = ~i_clear_from_writeback & ~i_data_stall & ~i_clear_from_alu;

  // Select the slice pair addressed by the counter and align its product.
  always_comb begin
    int idx_i;
    int idx_k;
    idx_i      = int'(cnt_r) / K;
    idx_k      = int'(cnt_r) % K;
    slice_a_s  = rm_mag_r[idx_i*SLICE_W +: SLICE_W];
    slice_b_s  = rs_mag_r[idx_k*SLICE_W +: SLICE_W];
    pp_shift_s = '0;
    pp_shift_s[2*SLICE_W-1:0] = pp_s;
    pp_shift_s = pp_shift_s << (SLICE_W * (idx_i + idx_k));
  end

  zap_mul_slice #(
    .SLICE_W (SLICE_W)
  ) u_mul_slice (
    .a (slice_a_s),
    .b (slice_b_s),
    .p (pp_s)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode with flush/stall priority applied ahead of the sequence.
  always_comb begin
    state_nxt_s = state_r;
    if (i_clear_from_writeback) begin
      state_nxt_s = ST_IDLE;
    end else if (i_data_stall) begin
      state_nxt_s = state_r;
    end else if (i_clear_from_alu) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = mac.i_start ? ST_MUL : ST_IDLE;
        ST_MUL:  state_nxt_s = (cnt_r == CNT_LAST) ? ST_FIX : ST_MUL;
        ST_FIX:  state_nxt_s = ST_ACC;
        ST_ACC:  state_nxt_s = ST_DONE;
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Operand capture, slice accumulation, sign fix-up and result load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_r    <= '0;
      rm_mag_r <= '0;
      rs_mag_r <= '0;
      neg_r    <= 1'b0;
      addend_r <= '0;
      prod_r   <= '0;
      rd_lo_r  <= '0;
      rd_hi_r  <= '0;
    end else if (flush_s) begin
      cnt_r    <= '0;
      addend_r <= '0;
      prod_r   <= '0;
    end else if (advance_s) begin
      case (state_r)
        ST_IDLE: begin
          if (mac.i_start) begin
            rm_mag_r <= magnitude(mac.i_rm, mac.i_signed);
            rs_mag_r <= magnitude(mac.i_rs, mac.i_signed);
            neg_r    <= mac.i_signed & (mac.i_rm[DATA_W-1] ^ mac.i_rs[DATA_W-1]);
            addend_r <= mac.i_acc ? {mac.i_rh, mac.i_rn} : '0;
            prod_r   <= '0;
            cnt_r    <= '0;
          end
        end
        ST_MUL: begin
          prod_r <= prod_r + pp_shift_s;
          cnt_r  <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
        end
        ST_FIX: begin
          if (neg_r) begin
            prod_r <= -prod_r;
          end
        end
        ST_ACC: begin
          {rd_hi_r, rd_lo_r} <= prod_r + addend_r;
        end
        ST_DONE: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign mac.o_rd_lo = rd_lo_r;
  assign mac.o_rd_hi = rd_hi_r;
  assign mac.o_done  = (state_r == ST_DONE);
  assign mac.o_busy  = (state_r == ST_MUL) || (state_r == ST_FIX) || (state_r == ST_ACC) ||
                       ((state_r == ST_IDLE) && mac.i_start);

endmodule

// File: tb/tb_zap_mac_seq.sv
// Directed bench for zap_mac_seq: vector table plus hand-written flush,
// stall and restart sequences.
module tb_zap_mac_seq;

  typedef struct {
    logic        sgn;
    logic        acc;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] rh;
    logic [31:0] rn;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_clear_from_writeback;
  logic i_data_stall;
  logic i_clear_from_alu;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl [13];

  zap_mac_seq_if #(.DATA_W(32)) mac ();

  zap_mac_seq #(
    .DATA_W  (32),
    .SLICE_W (16)
  ) dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .mac                    (mac)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mac.i_signed = v.sgn;
    mac.i_acc    = v.acc;
    mac.i_rm     = v.rm;
    mac.i_rs     = v.rs;
    mac.i_rh     = v.rh;
    mac.i_rn     = v.rn;
  endtask

  // Issue at the current negedge, optionally stall, then check latency and result.
  task automatic do_op(input vec_t v, input int stall_from, input int stall_len,
                       input int exp_lat, input string tag);
    int cyc;
    bit got;
    drive(v);
    mac.i_start = 1'b1;
    #1;
    chk({tag, " busy@start"}, 64'(mac.o_busy), 64'd1);
    @(negedge i_clk);
    mac.i_start = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      if (mac.o_done) begin
        got = 1'b1;
      end else begin
        if (cyc == stall_from) i_data_stall = 1'b1;
        if (cyc == stall_from + stall_len) i_data_stall = 1'b0;
        @(negedge i_clk);
        cyc++;
      end
    end
    i_data_stall = 1'b0;
    chk({tag, " done seen"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " hi"}, 64'(mac.o_rd_hi), 64'(v.hi));
    chk({tag, " lo"}, 64'(mac.o_rd_lo), 64'(v.lo));
    chk({tag, " busy@done"}, 64'(mac.o_busy), 64'd0);
    @(negedge i_clk);
    chk({tag, " done width"}, 64'(mac.o_done), 64'd0);
  endtask

  task automatic start_op(input vec_t v);
    drive(v);
    mac.i_start = 1'b1;
    @(negedge i_clk);
    mac.i_start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc, output bit got);
    cyc = cyc0;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      if (mac.o_done) got = 1'b1;
      else begin
        @(negedge i_clk);
        cyc++;
      end
    end
  endtask

  task automatic watch_no_done(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      if (mac.o_done) seen = 1'b1;
    end
    chk({tag, " no done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int  cyc;
    bit  got;
    vec_t v;

    //         sgn   acc   rm            rs            rh            rn            hi            lo
    tbl[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000001};
    tbl[1]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000005, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB};
    tbl[2]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000};
    tbl[3]  = '{1'b0, 1'b1, 32'h00000003, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h0000000E};
    tbl[4]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000};
    tbl[5]  = '{1'b0, 1'b0, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000};
    tbl[6]  = '{1'b1, 1'b0, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    tbl[7]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFD, 32'h00000000, 32'h00000064, 32'h00000000, 32'h0000004F};
    tbl[8]  = '{1'b0, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 32'h00000000, 32'h0000FFFE, 32'h00010000};
    tbl[9]  = '{1'b0, 1'b0, 32'h00000002, 32'h00000003, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000006};
    tbl[10] = '{1'b0, 1'b1, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    tbl[11] = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000};
    tbl[12] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h3FFFFFFF, 32'h00000001};

    i_reset                = 1'b1;
    i_clear_from_writeback = 1'b0;
    i_data_stall           = 1'b0;
    i_clear_from_alu       = 1'b0;
    mac.i_start            = 1'b0;
    drive(tbl[0]);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;

    chk("reset busy", 64'(mac.o_busy), 64'd0);
    chk("reset done", 64'(mac.o_done), 64'd0);
    chk("reset lo", 64'(mac.o_rd_lo), 64'd0);
    chk("reset hi", 64'(mac.o_rd_hi), 64'd0);

    // Consecutive entries start in the cycle right after DONE.
    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i], 0, 0, 7, $sformatf("vec%0d", i));
    end

    do_op(tbl[0], 2, 3, 10, "stall3");

    // ALU flush while in FIX: back to IDLE, no result, outputs held.
    start_op(tbl[9]);
    repeat (4) @(negedge i_clk);
    i_clear_from_alu = 1'b1;
    @(negedge i_clk);
    i_clear_from_alu = 1'b0;
    chk("clr_alu idle", 64'(mac.o_busy), 64'd0);
    watch_no_done(10, "clr_alu");
    chk("clr_alu hold hi", 64'(mac.o_rd_hi), 64'h00000000FFFFFFFE);
    chk("clr_alu hold lo", 64'(mac.o_rd_lo), 64'h0000000000000001);

    // ALU flush with stall: stall wins, operation completes one cycle late.
    start_op(tbl[9]);
    @(negedge i_clk);
    i_clear_from_alu = 1'b1;
    i_data_stall     = 1'b1;
    @(negedge i_clk);
    i_clear_from_alu = 1'b0;
    i_data_stall     = 1'b0;
    chk("stall>clr_alu busy", 64'(mac.o_busy), 64'd1);
    wait_done(3, cyc, got);
    chk("stall>clr_alu done", 64'(got), 64'd1);
    chk("stall>clr_alu latency", 64'(cyc), 64'd8);
    chk("stall>clr_alu lo", 64'(mac.o_rd_lo), 64'd6);
    @(negedge i_clk);

    // Writeback flush with stall: flush wins.
    v = tbl[9];
    v.rm = 32'd7;
    v.rs = 32'd7;
    start_op(v);
    @(negedge i_clk);
    i_clear_from_writeback = 1'b1;
    i_data_stall           = 1'b1;
    @(negedge i_clk);
    i_clear_from_writeback = 1'b0;
    i_data_stall           = 1'b0;
    chk("clr_wb>stall idle", 64'(mac.o_busy), 64'd0);
    watch_no_done(10, "clr_wb");
    chk("clr_wb hold lo", 64'(mac.o_rd_lo), 64'd6);
    chk("clr_wb hold hi", 64'(mac.o_rd_hi), 64'd0);

    // Restart request while busy is ignored; first operands win.
    v.rm = 32'd4;
    v.rs = 32'd5;
    start_op(v);
    @(negedge i_clk);
    v.rm = 32'd7;
    v.rs = 32'd7;
    drive(v);
    mac.i_start = 1'b1;
    @(negedge i_clk);
    mac.i_start = 1'b0;
    wait_done(3, cyc, got);
    chk("restart done", 64'(got), 64'd1);
    chk("restart latency", 64'(cyc), 64'd7);
    chk("restart lo", 64'(mac.o_rd_lo), 64'd20);
    chk("restart hi", 64'(mac.o_rd_hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
